draw_sequencer: RTL and testbench
=================================

DRAW_SEQUENCER -- requirements
Module: draw_sequencer

Interface
REQ-001 SHALL have parameter NUM_LINES, default 6, number of tile-line draw/erase engine pairs (2..16).
REQ-002 SHALL have parameter X_W, default 9, pixel x width (320 columns).
REQ-003 SHALL have parameter Y_W, default 8, pixel y width (240 rows).
REQ-004 SHALL have parameter COL_W, default 3, colour width.
REQ-005 SHALL have ports clock (in, 1, sole clock) and resetn (in, 1, asynchronous active-low reset).
REQ-006 SHALL have ports draw_go (in, 1, frame request), skip_erase (in, 1, draw-only mode) and dirty_mask (in, NUM_LINES, lines needing redraw).
REQ-007 SHALL have ports draw_done and erase_done (in, NUM_LINES each, per-engine completion).
REQ-008 SHALL have ports draw_x and erase_x (in, NUM_LINES*X_W, packed, line i at [i*X_W +: X_W]).
REQ-009 SHALL have ports draw_y and erase_y (in, NUM_LINES*Y_W, packed the same way).
REQ-010 SHALL have ports draw_col and erase_col (in, NUM_LINES*COL_W, packed the same way).
REQ-011 SHALL have ports draw_enable and erase_enable (out, NUM_LINES each, registered one-hot engine enables).
REQ-012 SHALL have ports vga_enable (out, 1, plot strobe), x_out (out, X_W), y_out (out, Y_W) and colour_out (out, COL_W).
REQ-013 SHALL have ports busy (out, 1, frame in progress) and all_draw_done (out, 1, one-cycle frame-complete pulse).

Function
REQ-014 SHALL implement FSM states IDLE, SCAN, ERASE, DRAW, DONE with a line index idx of $clog2(NUM_LINES) bits.
REQ-015 IDLE: on draw_go=1, SHALL latch dirty_mask and skip_erase, set idx=0 and go to SCAN; inputs are not sampled again until the next IDLE.
REQ-016 SCAN, one cycle per line: if mask[idx]=1 and skip=0, SHALL go to ERASE; if mask[idx]=1 and skip=1, SHALL go to DRAW.
REQ-017 SCAN: if mask[idx]=0, SHALL go to DONE when idx=NUM_LINES-1, otherwise increment idx and stay in SCAN.
REQ-018 ERASE: erase_enable[idx]=1, all other enables 0; on erase_done[idx]=1, SHALL go to DRAW.
REQ-019 DRAW: draw_enable[idx]=1; on draw_done[idx]=1, SHALL go to DONE when idx=NUM_LINES-1, otherwise increment idx and go to SCAN.
REQ-020 The enable SHALL drop on the edge after the cycle in which its done is seen high; a done asserted in the first enabled cycle is honoured.
REQ-021 DONE: all_draw_done=1 for exactly one cycle, then SHALL go to IDLE.
REQ-022 busy SHALL be 1 in SCAN, ERASE and DRAW, and 0 in IDLE and DONE.
REQ-023 At most one bit across draw_enable and erase_enable SHALL be high in any cycle.
REQ-024 vga_enable SHALL be combinational OR of all enable bits.
REQ-025 x_out, y_out and colour_out SHALL be combinational muxes from the active engine's slice.
REQ-026 With no enable active, x_out and y_out SHALL be 0 and colour_out SHALL be all ones.
REQ-027 done bits of inactive engines, and draw_go outside IDLE, SHALL be ignored.
REQ-028 Latency: draw_go sampled at edge 0 -> SCAN in cycle 1 -> first enable high in cycle 2.
REQ-029 An all-zero mask SHALL complete with all_draw_done high in cycle NUM_LINES+1 and no enable ever asserted.

Reset
REQ-030 resetn=0 SHALL asynchronously force IDLE, idx=0, all enables 0, busy 0, all_draw_done 0 and a cleared latched mask, so the outputs read 0,0,all ones with vga_enable 0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame without asserting all_draw_done; after release, only a new draw_go starts a frame.

Verification
REQ-032 NUM_LINES=6, mask=6'b111111, skip=0, each done returned 3 cycles after its enable -> enables in order e0,d0,e1,d1,...,d5, and a single all_draw_done pulse.
REQ-033 mask=6'b000100, skip=1 -> only draw_enable[2] asserted, in cycle 4, and colour_out equals draw_col slice 2 while it is high.
REQ-034 mask=0 -> all_draw_done in cycle 7, with vga_enable 0 throughout.
REQ-035 Stray done: erase_done[4] pulsed while erase_enable[1] is active, and draw_go re-pulsed mid-frame -> no state change, and no second frame afterwards.
REQ-036 resetn dropped during DRAW of line 3 -> enables 0 within the same cycle, no all_draw_done; a subsequent draw_go runs a full frame from line 0.
REQ-037 Immediate done (done=1 in the first enabled cycle) on every engine -> each enable is high for exactly one cycle, and the one-hot rule (REQ-023) holds every cycle.

Source files
------------

// File: rtl/draw_sequencer.sv
// Purpose : walks the dirty tile lines in order and runs each line's erase then draw engine, muxing the active engine onto the plot port.
// Latency : draw_go sampled at edge 0 -> SCAN in cycle 1 -> first engine enable in cycle 2; one SCAN cycle per line.
// Backpress: an engine holds the sequencer until its done bit is seen; draw_go is ignored while a frame is in flight.
//
// Ports:
//   clock, resetn                  sole clock, asynchronous active-low reset
//   draw_go, skip_erase, dirty_mask frame request, draw-only mode, per-line redraw mask (latched in IDLE)
//   draw_done, erase_done          per-engine completion, only the active engine's bit is looked at
//   draw_x/y/col, erase_x/y/col    packed per-engine pixel buses, line i at [i*W +: W]
//   draw_enable, erase_enable      registered one-hot engine enables
//   vga_enable, x_out, y_out, colour_out  plot strobe and pixel of the active engine
//   busy, all_draw_done            frame in progress, one-cycle frame-complete pulse
module draw_sequencer #(
    parameter int NUM_LINES = 6,
    parameter int X_W       = 9,
    parameter int Y_W       = 8,
    parameter int COL_W     = 3
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       draw_go,
    input  logic                       skip_erase,
    input  logic [NUM_LINES-1:0]       dirty_mask,
    input  logic [NUM_LINES-1:0]       draw_done,
    input  logic [NUM_LINES-1:0]       erase_done,
    input  logic [NUM_LINES*X_W-1:0]   draw_x,
    input  logic [NUM_LINES*X_W-1:0]   erase_x,
    input  logic [NUM_LINES*Y_W-1:0]   draw_y,
    input  logic [NUM_LINES*Y_W-1:0]   erase_y,
    input  logic [NUM_LINES*COL_W-1:0] draw_col,
    input  logic [NUM_LINES*COL_W-1:0] erase_col,
    output logic [NUM_LINES-1:0]       draw_enable,
    output logic [NUM_LINES-1:0]       erase_enable,
    output logic                       vga_enable,
    output logic [X_W-1:0]             x_out,
    output logic [Y_W-1:0]             y_out,
    output logic [COL_W-1:0]           colour_out,
    output logic                       busy,
    output logic                       all_draw_done
);

    localparam int               IDX_W    = $clog2(NUM_LINES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LINES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        ERASE,
        DRAW,
        DONE
    } state_t;

    state_t               state, state_nxt;
    logic [IDX_W-1:0]     idx, idx_nxt;
    logic [NUM_LINES-1:0] mask, mask_nxt;
    logic                 skip, skip_nxt;
    logic [NUM_LINES-1:0] line_sel;

    // Next-state logic. Done bits are only ever indexed by idx, so strays
    // from idle engines cannot move the FSM.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        mask_nxt  = mask;
        skip_nxt  = skip;
        case (state)
            IDLE: begin
                if (draw_go) begin
                    mask_nxt  = dirty_mask;
                    skip_nxt  = skip_erase;
                    idx_nxt   = '0;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (mask[idx]) begin
                    state_nxt = skip ? DRAW : ERASE;
                end else if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            ERASE: begin
                if (erase_done[idx]) begin
                    state_nxt = DRAW;
                end
            end
            DRAW: begin
                if (draw_done[idx]) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = SCAN;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Enables are registered from the next state so they rise with the
    // ERASE/DRAW state and fall on the edge after the done is seen.
    assign line_sel = NUM_LINES'(1) << idx_nxt;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            idx          <= '0;
            mask         <= '0;
            skip         <= 1'b0;
            draw_enable  <= '0;
            erase_enable <= '0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            mask         <= mask_nxt;
            skip         <= skip_nxt;
            erase_enable <= (state_nxt == ERASE) ? line_sel : '0;
            draw_enable  <= (state_nxt == DRAW)  ? line_sel : '0;
        end
    end

    assign busy          = (state == SCAN) || (state == ERASE) || (state == DRAW);
    assign all_draw_done = (state == DONE);
    assign vga_enable    = |{draw_enable, erase_enable};

    // Enables are one-hot, so at most one slice is selected; idle value is
    // black-on-white: coordinates 0, colour all ones.
    always_comb begin
        x_out      = '0;
        y_out      = '0;
        colour_out = '1;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (erase_enable[i]) begin
                x_out      = erase_x[i*X_W +: X_W];
                y_out      = erase_y[i*Y_W +: Y_W];
                colour_out = erase_col[i*COL_W +: COL_W];
            end
            if (draw_enable[i]) begin
                x_out      = draw_x[i*X_W +: X_W];
                y_out      = draw_y[i*Y_W +: Y_W];
                colour_out = draw_col[i*COL_W +: COL_W];
            end
        end
    end

endmodule

// File: tb/tb_draw_sequencer.sv
// Purpose : scoreboard bench for draw_sequencer; a frame-level model predicts engine order and cycle of every enable and the frame-done pulse.
// Latency : expectations are relative to the edge that samples draw_go (cycle 1 = SCAN of line 0).
// Backpress: engine responders return done after a per-frame latency and may toggle done bits of idle engines.
module tb_draw_sequencer;

    localparam int NL = 6;
    localparam int XW = 9;
    localparam int YW = 8;
    localparam int CW = 3;

    logic              clock;
    logic              resetn;
    logic              draw_go;
    logic              skip_erase;
    logic [NL-1:0]     dirty_mask;
    logic [NL-1:0]     draw_done;
    logic [NL-1:0]     erase_done;
    logic [NL*XW-1:0]  draw_x, erase_x;
    logic [NL*YW-1:0]  draw_y, erase_y;
    logic [NL*CW-1:0]  draw_col, erase_col;
    logic [NL-1:0]     draw_enable, erase_enable;
    logic              vga_enable;
    logic [XW-1:0]     x_out;
    logic [YW-1:0]     y_out;
    logic [CW-1:0]     colour_out;
    logic              busy;
    logic              all_draw_done;

    draw_sequencer #(.NUM_LINES(NL), .X_W(XW), .Y_W(YW), .COL_W(CW)) dut (
        .clock(clock), .resetn(resetn), .draw_go(draw_go), .skip_erase(skip_erase),
        .dirty_mask(dirty_mask), .draw_done(draw_done), .erase_done(erase_done),
        .draw_x(draw_x), .erase_x(erase_x), .draw_y(draw_y), .erase_y(erase_y),
        .draw_col(draw_col), .erase_col(erase_col),
        .draw_enable(draw_enable), .erase_enable(erase_enable), .vga_enable(vga_enable),
        .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
        .busy(busy), .all_draw_done(all_draw_done)
    );

    // kind: 0 = erase enable rises, 1 = draw enable rises, 2 = all_draw_done
    typedef struct {
        int kind;
        int line;
        int cyc;
    } ev_t;

    ev_t sb[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int g_cyc = 0;
    int cur_lat = 0;
    bit noise_on = 0;

    logic [XW-1:0] dxa [NL];
    logic [XW-1:0] exa [NL];
    logic [YW-1:0] dya [NL];
    logic [YW-1:0] eya [NL];
    logic [CW-1:0] dca [NL];
    logic [CW-1:0] eca [NL];

    logic [NL-1:0] prev_d, prev_e;
    bit            prev_done;
    int            dur_d [NL];
    int            dur_e [NL];
    int            dcnt  [NL];
    int            ecnt  [NL];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame model: line i is scanned at cycle t; a dirty line runs erase
    // (unless skipped) then draw, each enable lasting lat+1 cycles.
    task automatic build_expect(input logic [NL-1:0] m, input bit sk, input int lat);
        int t;
        int s;
        t = 1;
        for (int i = 0; i < NL; i++) begin
            if (m[i]) begin
                s = t + 1;
                if (!sk) begin
                    sb.push_back('{0, i, s});
                    s = s + lat + 1;
                end
                sb.push_back('{1, i, s});
                t = s + lat + 1;
            end else begin
                t = t + 1;
            end
        end
        sb.push_back('{2, 0, t});
    endtask

    task automatic randomize_data();
        for (int i = 0; i < NL; i++) begin
            dxa[i] = XW'($urandom); exa[i] = XW'($urandom);
            dya[i] = YW'($urandom); eya[i] = YW'($urandom);
            dca[i] = CW'($urandom); eca[i] = CW'($urandom);
            draw_x[i*XW +: XW]   = dxa[i]; erase_x[i*XW +: XW]   = exa[i];
            draw_y[i*YW +: YW]   = dya[i]; erase_y[i*YW +: YW]   = eya[i];
            draw_col[i*CW +: CW] = dca[i]; erase_col[i*CW +: CW] = eca[i];
        end
    endtask

    task automatic pop_check(input int kind, input int line);
        ev_t e;
        if (sb.size() == 0) begin
            chk(1'b0, "unexpected_event", kind * 100 + line, -1);
        end else begin
            e = sb.pop_front();
            chk(e.kind == kind, "event_kind", kind, e.kind);
            chk(e.line == line, "event_line", line, e.line);
            chk((cyc - g_cyc + 1) == e.cyc, "event_cycle", cyc - g_cyc + 1, e.cyc);
        end
    endtask

    // Engine responders: the enabled engine raises done in its (lat+1)-th
    // enabled cycle; idle engines may show random done noise.
    initial forever begin
        @(negedge clock);
        for (int i = 0; i < NL; i++) begin
            if (draw_enable[i]) begin
                dcnt[i]++;
                draw_done[i] = (dcnt[i] >= cur_lat + 1);
            end else begin
                dcnt[i] = 0;
                draw_done[i] = noise_on ? 1'($urandom) : 1'b0;
            end
            if (erase_enable[i]) begin
                ecnt[i]++;
                erase_done[i] = (ecnt[i] >= cur_lat + 1);
            end else begin
                ecnt[i] = 0;
                erase_done[i] = noise_on ? 1'($urandom) : 1'b0;
            end
        end
    end

    // Monitor: per-cycle output checks plus scoreboard pops on each event.
    initial forever begin : mon
        logic [XW-1:0] ex;
        logic [YW-1:0] ey;
        logic [CW-1:0] ec;
        @(negedge clock);
        if (!resetn) begin
            prev_d = '0;
            prev_e = '0;
            prev_done = 1'b0;
            for (int i = 0; i < NL; i++) begin
                dur_d[i] = 0;
                dur_e[i] = 0;
            end
        end else begin
            chk($countones({draw_enable, erase_enable}) <= 1, "one_hot",
                $countones({draw_enable, erase_enable}), 1);
            chk(vga_enable == |{draw_enable, erase_enable}, "vga_enable",
                int'(vga_enable), int'(|{draw_enable, erase_enable}));
            ex = '0; ey = '0; ec = '1;
            for (int i = 0; i < NL; i++) begin
                if (erase_enable[i]) begin ex = exa[i]; ey = eya[i]; ec = eca[i]; end
                if (draw_enable[i])  begin ex = dxa[i]; ey = dya[i]; ec = dca[i]; end
            end
            chk(x_out == ex, "x_out", int'(x_out), int'(ex));
            chk(y_out == ey, "y_out", int'(y_out), int'(ey));
            chk(colour_out == ec, "colour_out", int'(colour_out), int'(ec));
            for (int i = 0; i < NL; i++) begin
                if (draw_enable[i]) begin
                    dur_d[i]++;
                    if (!prev_d[i]) pop_check(1, i);
                end else if (prev_d[i]) begin
                    chk(dur_d[i] == cur_lat + 1, "draw_en_len", dur_d[i], cur_lat + 1);
                    dur_d[i] = 0;
                end
                if (erase_enable[i]) begin
                    dur_e[i]++;
                    if (!prev_e[i]) pop_check(0, i);
                end else if (prev_e[i]) begin
                    chk(dur_e[i] == cur_lat + 1, "erase_en_len", dur_e[i], cur_lat + 1);
                    dur_e[i] = 0;
                end
            end
            if (all_draw_done) begin
                pop_check(2, 0);
                chk(!prev_done, "done_pulse_width", 2, 1);
                chk(busy == 1'b0, "busy_in_done", int'(busy), 0);
            end
            if (vga_enable) chk(busy == 1'b1, "busy_while_enabled", int'(busy), 1);
            prev_d = draw_enable;
            prev_e = erase_enable;
            prev_done = all_draw_done;
        end
    end

    task automatic start_frame(input logic [NL-1:0] m, input bit sk, input int lat, input bit nz);
        @(negedge clock);
        cur_lat  = lat;
        noise_on = nz;
        randomize_data();
        build_expect(m, sk, lat);
        dirty_mask = m;
        skip_erase = sk;
        draw_go    = 1'b1;
        @(negedge clock);
        g_cyc      = cyc;
        draw_go    = 1'b0;
        dirty_mask = NL'($urandom);
        skip_erase = 1'($urandom);
    endtask

    task automatic finish_frame();
        int n;
        n = 0;
        forever begin
            @(negedge clock);
            if (sb.size() == 0) break;
            n++;
            if (n > 3000) begin
                chk(1'b0, "frame_timeout", n, 3000);
                sb.delete();
                break;
            end
            draw_go = (noise_on && $urandom_range(0, 7) == 0);
        end
        draw_go  = 1'b0;
        noise_on = 1'b0;
        repeat (3) begin
            @(negedge clock);
            chk(busy == 1'b0, "idle_busy", int'(busy), 0);
        end
    endtask

    task automatic run_frame(input logic [NL-1:0] m, input bit sk, input int lat, input bit nz);
        start_frame(m, sk, lat, nz);
        finish_frame();
    endtask

    task automatic check_idle_outputs(input string tag);
        chk(draw_enable == '0, {tag, "_draw_en"}, int'(draw_enable), 0);
        chk(erase_enable == '0, {tag, "_erase_en"}, int'(erase_enable), 0);
        chk(vga_enable == 1'b0, {tag, "_vga"}, int'(vga_enable), 0);
        chk(x_out == '0, {tag, "_x"}, int'(x_out), 0);
        chk(y_out == '0, {tag, "_y"}, int'(y_out), 0);
        chk(colour_out == {CW{1'b1}}, {tag, "_col"}, int'(colour_out), (1 << CW) - 1);
        chk(busy == 1'b0, {tag, "_busy"}, int'(busy), 0);
        chk(all_draw_done == 1'b0, {tag, "_done"}, int'(all_draw_done), 0);
    endtask

    task automatic reset_mid_draw();
        int n;
        start_frame(NL'($urandom) | NL'(8), 1'($urandom), 2, 1'b0);
        n = 0;
        while (!draw_enable[3]) begin
            @(negedge clock);
            n++;
            if (n > 500) begin
                chk(1'b0, "wait_draw3_timeout", n, 500);
                break;
            end
        end
        @(posedge clock);
        #2 resetn = 1'b0;
        #1 check_idle_outputs("mid_reset");
        sb.delete();
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        repeat (8) begin
            @(negedge clock);
            chk(busy == 1'b0, "post_reset_busy", int'(busy), 0);
            chk(vga_enable == 1'b0, "post_reset_vga", int'(vga_enable), 0);
        end
    endtask

    initial begin
        resetn     = 1'b0;
        draw_go    = 1'b0;
        skip_erase = 1'b0;
        dirty_mask = '0;
        draw_done  = '0;
        erase_done = '0;
        randomize_data();
        repeat (3) @(negedge clock);
        check_idle_outputs("reset");
        resetn = 1'b1;
        repeat (2) @(negedge clock);
        check_idle_outputs("after_reset");

        run_frame(6'b111111, 1'b0, 3, 1'b0);
        run_frame(6'b000100, 1'b1, $urandom_range(0, 3), 1'b0);
        run_frame(6'b000000, 1'b0, 0, 1'b0);
        run_frame(6'b110010, 1'b0, 2, 1'b1);
        run_frame(6'b111111, 1'b0, 0, 1'b1);
        run_frame(6'b111111, 1'b1, 0, 1'b0);
        reset_mid_draw();
        run_frame(6'b111111, 1'b0, 1, 1'b0);
        repeat (30) run_frame(NL'($urandom), 1'($urandom), $urandom_range(0, 3), 1'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout actual=%0d required=0", $time);
        $fatal(1, "watchdog");
    end

endmodule
